// File: rtl/door_pkg.sv
// door_pkg: state encoding and yt width shared by the door controller and its bench.
package door_pkg;
   localparam int YT_W = 3;
   typedef enum logic [YT_W-1:0] {
      CLOSED  = 3'd0,
      OPENING = 3'd1,
      OPEN    = 3'd2,
      CLOSING = 3'd3,
      LOCKED  = 3'd4,
      ALARM   = 3'd5,
      FAULT   = 3'd6
   } state_e;
endpackage

// File: rtl/door_ctrl_param_if.sv
// door_ctrl_param_if: sensor inputs and motor/status outputs of the door controller.
interface door_ctrl_param_if #(parameter int MAX_ATTEMPTS = 3);
   import door_pkg::*;
   localparam int FW = $clog2(MAX_ATTEMPTS + 1);
   logic pa, pp, mo, lk, l, m, r;
   logic m2l, l2m, m2r, r2m, bt, alarm, fault;
   logic [YT_W-1:0] yt;
   logic [FW-1:0] fail_cnt;
   modport master (
      output pa, pp, mo, lk, l, m, r,
      input  m2l, l2m, m2r, r2m, bt, alarm, fault, yt, fail_cnt
   );
   modport slave (
      input  pa, pp, mo, lk, l, m, r,
      output m2l, l2m, m2r, r2m, bt, alarm, fault, yt, fail_cnt
   );
endinterface

// File: rtl/door_timer.sv
// door_timer: saturating up/down counter; done flags the step that lands on the end value.
module door_timer #(
   parameter int W     = 3,
   parameter int LIMIT = 4,
   parameter bit UP    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);
   logic [W-1:0] q, nxt, tgt;
   assign tgt  = UP ? W'(LIMIT) : '0;
   assign nxt  = q == tgt ? q : UP ? q + 1'b1 : q - 1'b1;
   assign done = en && nxt == tgt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) q <= '0;
      else if (load) q <= UP ? '0 : W'(LIMIT);
      else if (en) q <= nxt;
endmodule

// File: rtl/door_ctrl_param.sv
// door_ctrl_param: two-leaf sliding door FSM with hold timer, obstruction reversal,
// expiring lock-attempt counter and latched motor-timeout fault.
module door_ctrl_param
   import door_pkg::*;
#(
   parameter int HOLD_CYCLES    = 4,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int ATTEMPT_WINDOW = 16,
   parameter int MOTOR_TIMEOUT  = 8
) (
   input  logic clk,
   input  logic reset,
   door_ctrl_param_if.slave bus
);
   localparam int FW = $clog2(MAX_ATTEMPTS + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int MW = $clog2(MOTOR_TIMEOUT + 1);
   localparam int WW = $clog2(ATTEMPT_WINDOW + 1);
   state_e state;
   logic mo_q;
   logic [FW-1:0] fail_cnt;
   logic attempt, someone, to_open, go_opening, go_closing;
   logic hold_done, mot_done, win_done;
   assign someone    = bus.pa | bus.pp;
   assign attempt    = bus.mo & ~mo_q;
   assign to_open    = state == OPENING && bus.l && bus.r;
   assign go_opening = (state == CLOSED && !bus.lk && (bus.pa | bus.mo)) || (state == CLOSING && someone);
   assign go_closing = state == OPEN && !someone && hold_done;
   door_timer #(.W(HW), .LIMIT(HOLD_CYCLES), .UP(1'b0)) u_hold (
      .clk, .reset, .load(to_open || (state == OPEN && someone)), .en(state == OPEN), .done(hold_done)
   );
   door_timer #(.W(MW), .LIMIT(MOTOR_TIMEOUT), .UP(1'b1)) u_motor (
      .clk, .reset, .load(go_opening || go_closing), .en(state == OPENING || state == CLOSING), .done(mot_done)
   );
   door_timer #(.W(WW), .LIMIT(ATTEMPT_WINDOW), .UP(1'b1)) u_window (
      .clk, .reset, .load(state == LOCKED && bus.lk && attempt), .en(state == LOCKED), .done(win_done)
   );
   // unlock beats a simultaneous attempt; an attempt restarts the window before expiry is considered
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= CLOSED;
         mo_q     <= 1'b0;
         fail_cnt <= '0;
      end else begin
         mo_q <= bus.mo;
         case (state)
            CLOSED:  state <= bus.lk ? LOCKED : go_opening ? OPENING : CLOSED;
            OPENING: state <= to_open ? OPEN : mot_done ? FAULT : OPENING;
            OPEN:    state <= go_closing ? CLOSING : OPEN;
            CLOSING: state <= go_opening ? OPENING : bus.m ? CLOSED : mot_done ? FAULT : CLOSING;
            LOCKED:
               if (!bus.lk) begin
                  state    <= CLOSED;
                  fail_cnt <= '0;
               end else if (attempt) begin
                  state    <= fail_cnt + 1'b1 == FW'(MAX_ATTEMPTS) ? ALARM : LOCKED;
                  fail_cnt <= fail_cnt + 1'b1;
               end else if (win_done) fail_cnt <= '0;
            ALARM:   state <= ALARM;
            FAULT:   state <= FAULT;
            default: state <= CLOSED;
         endcase
      end
   assign bus.m2l      = state == OPENING;
   assign bus.m2r      = state == OPENING;
   assign bus.l2m      = state == CLOSING;
   assign bus.r2m      = state == CLOSING;
   assign bus.bt       = state == LOCKED || state == ALARM;
   assign bus.alarm    = state == ALARM;
   assign bus.fault    = state == FAULT;
   assign bus.yt       = state;
   assign bus.fail_cnt = fail_cnt;
endmodule

// File: tb/tb_door_ctrl_param.sv
// tb_door_ctrl_param: directed vectors with hand-computed states for the door controller.
module tb_door_ctrl_param;
   import door_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   door_ctrl_param_if bus ();
   door_ctrl_param dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // order: pa pp mo lk l m r
   task automatic drive(input logic [6:0] v);
      {bus.pa, bus.pp, bus.mo, bus.lk, bus.l, bus.m, bus.r} = v;
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   function automatic logic [3:0] motors();
      return {bus.m2l, bus.l2m, bus.m2r, bus.r2m};
   endfunction
   localparam logic [6:0] PA = 7'b1000000, PP = 7'b0100000, MO = 7'b0010000, LK = 7'b0001000;
   localparam logic [6:0] LR = 7'b0000101, MID = 7'b0000010;
   initial begin
      drive(7'b0);
      #1;
      check("rst_yt", bus.yt, CLOSED);
      check("rst_motors", motors(), 4'b0000);
      check("rst_flags", {bus.bt, bus.alarm, bus.fault}, 3'b000);
      check("rst_fail_cnt", bus.fail_cnt, 0);
      @(negedge clk);
      reset = 1'b1;
      drive(PA); step(1);
      check("n_opening", bus.yt, OPENING);
      check("n_open_motors", motors(), 4'b1010);
      drive(7'b0); step(1);
      check("n_still_opening", bus.yt, OPENING);
      drive(LR); step(1);
      check("n_open", bus.yt, OPEN);
      check("n_open_motors_off", motors(), 4'b0000);
      step(3);
      check("n_hold", bus.yt, OPEN);
      step(1);
      check("n_closing", bus.yt, CLOSING);
      check("n_close_motors", motors(), 4'b0101);
      drive(MID); step(1);
      check("n_closed", bus.yt, CLOSED);
      check("n_closed_motors", motors(), 4'b0000);
      drive(PA); step(1);
      drive(LR); step(1);
      check("o_open", bus.yt, OPEN);
      step(2);
      drive(PA | LR); step(1);
      check("o_reload", bus.yt, OPEN);
      drive(LR); step(3);
      check("o_reload_hold", bus.yt, OPEN);
      step(1);
      check("o_closing", bus.yt, CLOSING);
      drive(PP | MID); step(1);
      check("o_reverse", bus.yt, OPENING);
      check("o_reverse_motors", motors(), 4'b1010);
      drive(LR); step(1);
      check("o_reopen", bus.yt, OPEN);
      step(3);
      check("o_hold_after_pp", bus.yt, OPEN);
      step(1);
      check("o_closing2", bus.yt, CLOSING);
      drive(MID); step(1);
      check("o_closed", bus.yt, CLOSED);
      drive(LK); step(1);
      check("a_locked", bus.yt, LOCKED);
      check("a_bolted", bus.bt, 1);
      drive(PA | PP | LK); step(1);
      check("a_ignore_pa_pp", bus.yt, LOCKED);
      for (int i = 1; i <= 2; i++) begin
         drive(MO | LK); step(1);
         check($sformatf("a_cnt%0d", i), bus.fail_cnt, i);
         check($sformatf("a_locked%0d", i), bus.yt, LOCKED);
         drive(LK); step(2);
      end
      drive(MO | LK); step(1);
      check("a_alarm", bus.yt, ALARM);
      check("a_alarm_flags", {bus.bt, bus.alarm, bus.fault}, 3'b110);
      check("a_alarm_cnt", bus.fail_cnt, 3);
      drive(PA); step(2);
      check("a_absorbing", bus.yt, ALARM);
      reset = 1'b0;
      #1;
      check("a_reset_yt", bus.yt, CLOSED);
      check("a_reset_alarm", bus.alarm, 0);
      check("a_reset_cnt", bus.fail_cnt, 0);
      @(negedge clk);
      reset = 1'b1;
      drive(LK); step(1);
      drive(MO | LK); step(1);
      check("w_cnt1", bus.fail_cnt, 1);
      drive(LK); step(1);
      drive(MO | LK); step(1);
      check("w_cnt2", bus.fail_cnt, 2);
      drive(LK); step(15);
      check("w_before_expiry", bus.fail_cnt, 2);
      step(1);
      check("w_expired", bus.fail_cnt, 0);
      check("w_still_locked", bus.yt, LOCKED);
      drive(MO | LK); step(1);
      check("w_cnt_again", bus.fail_cnt, 1);
      drive(LK); step(1);
      drive(MO); step(1);
      check("u_unlock_wins", bus.yt, CLOSED);
      check("u_unlock_clears", bus.fail_cnt, 0);
      drive(MO | LK); step(1);
      check("h_lock_over_mo", bus.yt, LOCKED);
      step(2);
      check("h_held_mo_no_count", bus.fail_cnt, 0);
      drive(7'b0); step(1);
      check("h_unlocked", bus.yt, CLOSED);
      drive(PA); step(1);
      check("f_opening", bus.yt, OPENING);
      drive(7'b0); step(7);
      check("f_before_timeout", bus.yt, OPENING);
      step(1);
      check("f_fault", bus.yt, FAULT);
      check("f_fault_flag", bus.fault, 1);
      check("f_motors_off", motors(), 4'b0000);
      drive(PA | LR); step(2);
      check("f_absorbing", bus.yt, FAULT);
      reset = 1'b0;
      #1;
      check("f_reset_yt", bus.yt, CLOSED);
      check("f_reset_fault", bus.fault, 0);
      @(negedge clk);
      reset = 1'b1;
      drive(7'b0);
      drive(PA | LK); step(1);
      check("p_lock_over_pa", bus.yt, LOCKED);
      drive(7'b0); step(1);
      check("p_unlocked", bus.yt, CLOSED);
      drive(PA); step(1);
      drive(LR); step(5);
      check("r_closing", motors(), 4'b0101);
      drive(7'b0);
      #2;
      reset = 1'b0;
      #1;
      check("r_async_motors", motors(), 4'b0000);
      check("r_async_yt", bus.yt, CLOSED);
      @(negedge clk);
      reset = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
